// File: rtl/ibus_if_pkg.sv
// Shared types and encodings for the instruction-fetch bus interface.
// Used by ibus_if and its halfword queue.
package ibus_pkg;

  localparam logic [1:0] VLD_NONE   = 2'b00;
  localparam logic [1:0] VLD_16     = 2'b01;
  localparam logic [1:0] VLD_32     = 2'b10;
  localparam logic [1:0] HSIZE_WORD = 2'b10;

  typedef struct packed {
    logic [15:0] data;
    logic        fault;
  } hw_entry_t;

endpackage

// File: rtl/ibus_if_hwq.sv
// Halfword FIFO: 1/2-halfword push, 1/2-halfword pop, flush wins.
// Pointers wrap modulo HW_DEPTH, so the depth need not be a power of two.
module ibus_if_hwq
  import ibus_pkg::*;
#(
  parameter int HW_DEPTH = 4,
  localparam int CW = $clog2(HW_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic          i_push_two,
  input  hw_entry_t     i_push_lo,
  input  hw_entry_t     i_push_hi,
  input  logic          i_pop,
  input  logic          i_pop_two,
  output logic [CW-1:0] o_cnt,
  output hw_entry_t     o_h0,
  output hw_entry_t     o_h1
);

  localparam int AW = (HW_DEPTH > 1) ? $clog2(HW_DEPTH) : 1;

  hw_entry_t     r_mem [HW_DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  int            w_pushn;
  int            w_popn;

  function automatic logic [AW-1:0] f_adv(
    input logic [AW-1:0] p,
    input int            k
  );
    int s;
    s = int'(p) + k;
    if (s >= HW_DEPTH) s = s - HW_DEPTH;
    return AW'(s);
  endfunction

  always_comb begin
    w_pushn = 0;
    w_popn  = 0;
    if (i_push) w_pushn = i_push_two ? 2 : 1;
    if (i_pop)  w_popn  = i_pop_two ? 2 : 1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      r_rd  <= f_adv(r_rd, w_popn);
      r_wr  <= f_adv(r_wr, w_pushn);
      r_cnt <= CW'(int'(r_cnt) + w_pushn - w_popn);
    end
  end

  // A single push stores only the high halfword (misaligned jump target)
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr] <= i_push_two ? i_push_lo : i_push_hi;
      if (i_push_two) r_mem[f_adv(r_wr, 1)] <= i_push_hi;
    end
  end

  assign o_cnt = r_cnt;
  assign o_h0  = r_mem[r_rd];
  assign o_h1  = r_mem[f_adv(r_rd, 1)];

endmodule

// File: rtl/ibus_if.sv
// Instruction-fetch AHB-Lite read port feeding a halfword prefetch queue.
// IBUS_IF_FAULT_HALT_EN: stop prefetching after an errored fetch until jump.
module ibus_if
  import ibus_pkg::*;
#(
  parameter int HW_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        jmp_req,
  input  logic [31:0] jmp_addr,
  input  logic        instr_fetch,
  input  logic [1:0]  instr_fetch_size,
  output logic [1:0]  instr_vld_size,
  output logic [31:0] instr,
  output logic        instr_has_fault,
  output logic [31:0] haddr,
  output logic        hprot,
  output logic [1:0]  hsize,
  output logic [31:0] hwdata,
  output logic        htrans,
  output logic        hwrite,
  input  logic [31:0] hrdata,
  input  logic        hresp,
  input  logic        hready
);

  localparam int CW = $clog2(HW_DEPTH + 1);

  logic          r_en;
  logic          r_dph;
  logic          r_stale;
  logic          r_skip;
  logic [31:0]   r_haddr;
  logic [CW-1:0] w_cnt;
  hw_entry_t     w_h0;
  hw_entry_t     w_h1;
  hw_entry_t     w_lo;
  hw_entry_t     w_hi;
  logic          w_done;
  logic          w_acc;
  logic          w_push;
  logic          w_pop;
  logic          w_err1;
  logic          w_halt;
  logic          w_space;
  logic          w_has1;
  logic          w_has2;
  logic          w_unused;
  int            w_free;
  int            w_infl;

  assign w_done = r_dph & hready;
  assign w_err1 = r_dph & hresp & ~hready;

  // A stale (pre-jump) data phase will never land in the queue
  always_comb begin
    w_free  = HW_DEPTH - int'(w_cnt);
    w_infl  = (r_dph && !r_stale) ? 2 : 0;
    w_space = (w_free - w_infl) >= 2;
  end

`ifdef IBUS_IF_FAULT_HALT_EN
  assign w_halt = r_dph & ~r_stale & hresp;
`else
  assign w_halt = 1'b0;
`endif

  assign htrans = jmp_req | (r_en & w_space & ~w_err1 & ~w_halt);
  assign haddr  = jmp_req ? {jmp_addr[31:2], 2'b00} : r_haddr;
  assign w_acc  = htrans & hready;
  assign w_push = w_done & ~r_stale & ~jmp_req;

  assign w_lo = '{data: hrdata[15:0],  fault: hresp};
  assign w_hi = '{data: hrdata[31:16], fault: hresp};

  assign w_pop = instr_fetch & ~jmp_req &
                 (instr_fetch_size[0] ? (w_cnt >= CW'(1))
                                      : (w_cnt >= CW'(2)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_en    <= 1'b0;
      r_dph   <= 1'b0;
      r_stale <= 1'b0;
      r_skip  <= 1'b0;
      r_haddr <= '0;
    end else begin
      if (w_acc)        r_haddr <= haddr + 32'd4;
      else if (jmp_req) r_haddr <= haddr;
      if (w_acc)        r_dph <= 1'b1;
      else if (w_done)  r_dph <= 1'b0;
      if (jmp_req)      r_stale <= r_dph & ~hready;
      else if (w_acc | w_done) r_stale <= 1'b0;
      if (jmp_req)      r_skip <= jmp_addr[1];
      else if (w_push)  r_skip <= 1'b0;
`ifdef IBUS_IF_FAULT_HALT_EN
      if (jmp_req)      r_en <= 1'b1;
      else if (w_push & hresp) r_en <= 1'b0;
`else
      if (jmp_req)      r_en <= 1'b1;
`endif
    end
  end

  ibus_if_hwq #(.HW_DEPTH(HW_DEPTH)) u_hwq (
    .clk        (clk),
    .rstn       (rstn),
    .i_flush    (jmp_req),
    .i_push     (w_push),
    .i_push_two (~r_skip),
    .i_push_lo  (w_lo),
    .i_push_hi  (w_hi),
    .i_pop      (w_pop),
    .i_pop_two  (~instr_fetch_size[0]),
    .o_cnt      (w_cnt),
    .o_h0       (w_h0),
    .o_h1       (w_h1)
  );

  assign w_has1 = (w_cnt != '0) & ~jmp_req;
  assign w_has2 = (w_cnt >= CW'(2)) & ~jmp_req;

  assign instr_vld_size = w_has2 ? VLD_32 : (w_has1 ? VLD_16 : VLD_NONE);
  assign instr = {w_has2 ? w_h1.data : 16'h0,
                  w_has1 ? w_h0.data : 16'h0};
  assign instr_has_fault = (w_has1 & w_h0.fault) | (w_has2 & w_h1.fault);

  assign hprot  = 1'b0;
  assign hsize  = HSIZE_WORD;
  assign hwdata = '0;
  assign hwrite = 1'b0;

  assign w_unused = ^{jmp_addr[0], instr_fetch_size[1]};

endmodule

// File: tb/tb_ibus_if.sv
// Bench for ibus_if: AHB slave model plus an instruction-stream reference.
// Expected halfwords come from a program counter walking the address map.
module tb_ibus_if;

  logic        clk = 1'b0;
  logic        rstn;
  logic        jmp_req;
  logic [31:0] jmp_addr;
  logic        instr_fetch;
  logic [1:0]  instr_fetch_size;
  logic [1:0]  instr_vld_size;
  logic [31:0] instr;
  logic        instr_has_fault;
  logic [31:0] haddr;
  logic        hprot;
  logic [1:0]  hsize;
  logic [31:0] hwdata;
  logic        htrans;
  logic        hwrite;
  logic [31:0] hrdata;
  logic        hresp;
  logic        hready;

  localparam int DEPTH = 4;

  ibus_if #(.HW_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .jmp_req          (jmp_req),
    .jmp_addr         (jmp_addr),
    .instr_fetch      (instr_fetch),
    .instr_fetch_size (instr_fetch_size),
    .instr_vld_size   (instr_vld_size),
    .instr            (instr),
    .instr_has_fault  (instr_has_fault),
    .haddr            (haddr),
    .hprot            (hprot),
    .hsize            (hsize),
    .hwdata           (hwdata),
    .htrans           (htrans),
    .hwrite           (hwrite),
    .hrdata           (hrdata),
    .hresp            (hresp),
    .hready           (hready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model: stream position, queued halfwords, fetch address
  logic [31:0] pc;
  logic [31:0] fa;
  int          q;
  int          epoch;
  bit          skip;
  int          popped;

  // slave model
  bit          s_dph, s_err, s_errph;
  logic [31:0] s_addr;
  int          s_wait, s_ep;
  int          err_mode, maxw, fixw;
  int          err_seen;

  logic        sv_htrans, sv_hready;
  logic [31:0] sv_haddr;
  logic [1:0]  o_vld;
  logic [31:0] o_instr;
  logic        o_flt, o_htrans;
  logic [31:0] o_haddr;

  function automatic logic [15:0] hw(input logic [31:0] h);
    logic [7:0] b0, b1;
    b0 = h[7:0];
    b1 = h[7:0] + 8'd1;
    return {b1, b0};
  endfunction

  function automatic bit is_err(input logic [31:0] a);
    if (err_mode == 1) return a == 32'h40;
    if (err_mode == 2) return (a[31:2] % 30'd11) == 30'd3;
    return 1'b0;
  endfunction

  function automatic bit flt(input logic [31:0] h);
    return is_err({h[31:2], 2'b00});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic slave_drive();
    if (s_dph) begin
      hrdata = {hw(s_addr + 32'd2), hw(s_addr)};
      if (s_err) begin
        hresp  = 1'b1;
        hready = s_errph;
      end else begin
        hresp  = 1'b0;
        hready = (s_wait == 0);
      end
    end else begin
      hrdata = $urandom;
      hresp  = 1'b0;
      hready = 1'b1;
    end
  endtask

  // fm: 0 none, 1 random, 2 16-bit when valid, 3 always 32-bit
  task automatic cycle(input bit j, input logic [31:0] ja, input int fm);
    int ve, need, n;
    logic [31:0] ei;
    bit ef, done;
    jmp_req  = j;
    jmp_addr = ja;
    #1;
    instr_fetch      = 1'b0;
    instr_fetch_size = 2'b00;
    case (fm)
      1: begin
        instr_fetch      = 1'($urandom % 2);
        instr_fetch_size = 2'($urandom % 4);
      end
      2: begin
        instr_fetch      = (instr_vld_size != 2'b00);
        instr_fetch_size = 2'b01;
      end
      3: instr_fetch = 1'b1;
      default: ;
    endcase
    @(negedge clk);
    o_vld = instr_vld_size;
    o_instr = instr;
    o_flt = instr_has_fault;
    o_htrans = htrans;
    o_haddr = haddr;
    sv_htrans = htrans;
    sv_hready = hready;
    sv_haddr = haddr;
    ve = j ? 0 : (q >= 2 ? 2 : q);
    ei = 32'h0;
    ef = 1'b0;
    if (ve >= 1) begin
      ei[15:0] = hw(pc);
      ef = flt(pc);
    end
    if (ve == 2) begin
      ei[31:16] = hw(pc + 32'd2);
      ef = ef | flt(pc + 32'd2);
    end
    chk("vld", 32'(o_vld), 32'(ve));
    chk("instr", o_instr, ei);
    chk("fault", 32'(o_flt), 32'(ef));
    chk("busconst", {hwdata[27:0], hprot, hwrite, haddr[1:0]},
        32'h0);
    chk("hsize", 32'(hsize), 32'h2);
    if (j) begin
      fa = {ja[31:2], 2'b00};
      chk("jmp_htrans", 32'(htrans), 32'h1);
      chk("jmp_haddr", haddr, fa);
    end
    if (s_dph && s_err && !s_errph && !j) begin
      err_seen++;
      chk("err_htrans", 32'(htrans), 32'h0);
    end
    if (htrans && !j)
      chk("space", 32'(q + ((s_dph && s_ep == epoch) ? 2 : 0) <= DEPTH - 2),
          32'h1);
    if (htrans && hready) begin
      chk("fetch_addr", haddr, fa);
      fa = fa + 32'd4;
    end
    @(posedge clk);
    done = s_dph && sv_hready;
    if (!j && instr_fetch) begin
      need = instr_fetch_size[0] ? 1 : 2;
      if (q >= need) begin
        q = q - need;
        pc = pc + 32'(2 * need);
        popped = popped + need;
      end
    end
    if (done && s_ep == epoch && !j) begin
      n = skip ? 1 : 2;
      q = q + n;
      skip = 1'b0;
    end
    if (j) begin
      epoch++;
      q = 0;
      pc = {ja[31:1], 1'b0};
      skip = ja[1];
    end
    if (s_dph) begin
      if (sv_hready) s_dph = 1'b0;
      else if (s_err) s_errph = 1'b1;
      else s_wait--;
    end
    if (sv_htrans && sv_hready) begin
      s_dph = 1'b1;
      s_addr = sv_haddr;
      s_err = is_err(sv_haddr);
      s_errph = 1'b0;
      s_wait = (fixw >= 0) ? fixw : int'($urandom_range(0, maxw));
      s_ep = epoch;
    end
    #1;
    slave_drive();
  endtask

  initial begin
    bit found;
    int n;
    int fseen;
    logic [15:0] got [3];
    rstn = 1'b0;
    jmp_req = 1'b0;
    jmp_addr = '0;
    instr_fetch = 1'b0;
    instr_fetch_size = 2'b00;
    hrdata = '0;
    hresp = 1'b0;
    hready = 1'b1;
    pc = '0; fa = '0; q = 0; epoch = 0; skip = 1'b0; popped = 0;
    s_dph = 1'b0; s_err = 1'b0; s_errph = 1'b0; s_addr = '0;
    s_wait = 0; s_ep = 0;
    err_mode = 0; maxw = 0; fixw = 0; err_seen = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_htrans", 32'(htrans), 32'h0);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_vld", 32'(instr_vld_size), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_fault", 32'(instr_has_fault), 32'h0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    slave_drive();

    repeat (3) cycle(1'b0, 32'h0, 1);
    chk("idle_htrans", 32'(o_htrans), 32'h0);

    // 1: jump to 0, zero-wait latency
    cycle(1'b1, 32'h0, 0);
    chk("t1_aph", {31'h0, o_htrans}, 32'h1);
    cycle(1'b0, 32'h0, 0);
    chk("t1_lat", 32'(o_vld), 32'h0);
    cycle(1'b0, 32'h0, 0);
    chk("t1_vld", 32'(o_vld), 32'h2);
    chk("t1_instr", o_instr, 32'h03020100);
    repeat (12) cycle(1'b0, 32'h0, 3);

    // 2: misaligned target, 32-bit consume
    cycle(1'b1, 32'h2, 3);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(1'b0, 32'h0, 3);
      if (o_vld == 2'b10) begin
        found = 1'b1;
        chk("t2_first", o_instr, 32'h05040302);
      end
    end
    chk("t2_found", 32'(found), 32'h1);
    repeat (12) cycle(1'b0, 32'h0, 3);

    // 3: 16-bit consume whenever valid
    cycle(1'b1, 32'h2, 2);
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      cycle(1'b0, 32'h0, 2);
      if (o_vld != 2'b00) begin
        got[n] = o_instr[15:0];
        n++;
      end
    end
    chk("t3_count", 32'(n), 32'h3);
    chk("t3_hw0", 32'(got[0]), 32'h0302);
    chk("t3_hw1", 32'(got[1]), 32'h0504);
    chk("t3_hw2", 32'(got[2]), 32'h0706);

    // 4: error response on word 0x40
    err_mode = 1;
    err_seen = 0;
    fseen = 0;
    cycle(1'b1, 32'h38, 2);
    for (int i = 0; i < 24; i++) begin
      cycle(1'b0, 32'h0, 2);
      if (o_flt) fseen++;
    end
    chk("t4_errcyc", 32'(err_seen > 0), 32'h1);
    chk("t4_fault", 32'(fseen > 0), 32'h1);
    err_mode = 0;

    // 5: jump while a wait-stated data phase is pending
    fixw = 3;
    cycle(1'b1, 32'h104, 0);
    cycle(1'b0, 32'h0, 0);
    cycle(1'b1, 32'h210, 0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle(1'b0, 32'h0, 0);
      if (o_vld != 2'b00) begin
        found = 1'b1;
        chk("t5_first", 32'(o_instr[15:0]), 32'h1110);
      end
    end
    chk("t5_found", 32'(found), 32'h1);

    // 6: 32-bit request with a single halfword queued
    fixw = 4;
    cycle(1'b1, 32'h2, 3);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b0, 32'h0, 3);
      if (o_vld == 2'b01) found = 1'b1;
    end
    chk("t6_found", 32'(found), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'h0, 3);
      chk("t6_hold", 32'(o_vld), 32'h1);
      chk("t6_instr", o_instr, 32'h0302);
    end

    // random traffic: waits, errors, jumps, mixed consumption
    fixw = -1;
    maxw = 2;
    err_mode = 2;
    popped = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 40 == 0)
        cycle(1'b1, 32'($urandom_range(0, 1023)) & ~32'h1, 1);
      else
        cycle(1'b0, 32'h0, 1);
    end
    chk("rand_progress", 32'(popped > 300), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
